// File: rtl/pipe_pkg.sv
// Shared types for the elastic pipeline stage: occupancy states and the ID/EX payload layout.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } pipe_state_e;

    typedef struct packed {
        logic [4:0]  rd_addr;
        logic [7:0]  brcomp;
        logic [17:0] ctrl;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [31:0] pc;
    } idex_bundle_t;

    localparam int IDEX_W = $bits(idex_bundle_t);

    function automatic logic is_occupied(input pipe_state_e st);
        return st != EMPTY;
    endfunction

endpackage

// File: rtl/pipe_perf_cnt.sv
// Single wrapping 32-bit event counter, cleared by the asynchronous reset.
module pipe_perf_cnt (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        inc_i,
    output logic [31:0] cnt_o
);

    logic [31:0] cnt_q;
    logic [31:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic valid/ready pipeline register with optional skid entry and synchronous flush.
// Define PIPE_STAGE_PERF_EN to add stall/flush event counters.
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int DATA_W         = IDEX_W,
    parameter bit SKID           = 1'b1,
    parameter bit ZERO_ON_BUBBLE = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [31:0]       stall_cnt_o,
    output logic [31:0]       flush_cnt_o
`endif
);

    pipe_state_e       state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              ready_q, ready_d;
    logic              in_fire;
    logic              out_fire;

    assign out_valid_o = is_occupied(state_q);
    // Without a skid entry the stage can only accept when it will be vacated this cycle.
    assign in_ready_o  = SKID ? ready_q : (!out_valid_o || out_ready_i);
    assign in_fire     = in_valid_i && in_ready_o;
    assign out_fire    = out_valid_o && out_ready_i;
    assign out_data_o  = (ZERO_ON_BUBBLE && !out_valid_o) ? '0 : main_q;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        ready_d = ready_q;

        if (flush_i) begin
            state_d = EMPTY;
            skid_d  = '0;
            ready_d = 1'b1;
            if (ZERO_ON_BUBBLE) begin
                main_d = '0;
            end
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d = FULL;
                        main_d  = in_data_i;
                    end
                end
                FULL: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data_i;
                    end else if (in_fire && SKID) begin
                        state_d = pipe_pkg::SKID;
                        skid_d  = in_data_i;
                        ready_d = 1'b0;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                        if (ZERO_ON_BUBBLE) begin
                            main_d = '0;
                        end
                    end
                end
                pipe_pkg::SKID: begin
                    // The parked beat moves up to the output; upstream reopens next cycle.
                    if (out_fire) begin
                        state_d = FULL;
                        main_d  = skid_q;
                        skid_d  = '0;
                        ready_d = 1'b1;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    main_d  = '0;
                    skid_d  = '0;
                    ready_d = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            ready_q <= ready_d;
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    logic stall_ev;
    logic flush_ev;

    assign stall_ev = out_valid_o && !out_ready_i;
    assign flush_ev = flush_i && (state_q != EMPTY);

    pipe_perf_cnt u_stall_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc_i  (stall_ev),
        .cnt_o  (stall_cnt_o)
    );

    pipe_perf_cnt u_flush_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc_i  (flush_ev),
        .cnt_o  (flush_cnt_o)
    );
`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed bench for pipe_stage_elastic: skid/zero-on-bubble instance with scoreboard, plus a SKID=0 instance.
module tb_pipe_stage_elastic;
    import pipe_pkg::*;

    localparam int W  = IDEX_W;
    localparam int W0 = 16;

    logic          clk_i;
    logic          rst_ni;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;

    logic          s0_flush;
    logic          s0_in_valid;
    logic          s0_in_ready;
    logic [W0-1:0] s0_in_data;
    logic          s0_out_valid;
    logic          s0_out_ready;
    logic [W0-1:0] s0_out_data;

`ifdef PIPE_STAGE_PERF_EN
    logic [31:0]   stall_cnt;
    logic [31:0]   flush_cnt;
    logic [31:0]   s0_stall_cnt;
    logic [31:0]   s0_flush_cnt;
`endif

    int            nchk;
    int            npass;
    logic [W-1:0]  sb[$];

    pipe_stage_elastic #(.DATA_W(W), .SKID(1'b1), .ZERO_ON_BUBBLE(1'b1)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .stall_cnt_o (stall_cnt),
        .flush_cnt_o (flush_cnt)
`endif
    );

    pipe_stage_elastic #(.DATA_W(W0), .SKID(1'b0), .ZERO_ON_BUBBLE(1'b0)) dut0 (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .flush_i     (s0_flush),
        .in_valid_i  (s0_in_valid),
        .in_ready_o  (s0_in_ready),
        .in_data_i   (s0_in_data),
        .out_valid_o (s0_out_valid),
        .out_ready_i (s0_out_ready),
        .out_data_o  (s0_out_data)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .stall_cnt_o (s0_stall_cnt),
        .flush_cnt_o (s0_flush_cnt)
`endif
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [W-1:0] mkd(input int n);
        idex_bundle_t b;
        b.rd_addr  = 5'(n);
        b.brcomp   = 8'(n) ^ 8'hA5;
        b.ctrl     = 18'(n * 7);
        b.rs1_data = 32'(n * 3);
        b.rs2_data = ~32'(n);
        b.imm      = 32'(n + 100);
        b.pc       = 32'(n) << 2;
        return b;
    endfunction

    // Scoreboard: handshakes are sampled mid-cycle, where inputs are stable until the next edge.
    always @(negedge clk_i) begin
        if (!rst_ni) begin
            sb.delete();
        end else begin
            if (!out_valid) check("bubble_zero", out_data, '0);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    nchk++;
                    $error("FAIL sb_empty: observed %0h expected no beat", out_data);
                end else begin
                    check("sb_data", out_data, sb.pop_front());
                end
            end
            if (flush) sb.delete();
            else if (in_valid && in_ready) sb.push_back(in_data);
        end
    end

    initial begin
        nchk = 0; npass = 0;
        rst_ni = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        s0_flush = 1'b0; s0_in_valid = 1'b0; s0_in_data = '0; s0_out_ready = 1'b0;
        #12;
        check("rst_out_valid", W'(out_valid), W'(1'b0));
        check("rst_out_data",  out_data, '0);
        check("rst_in_ready",  W'(in_ready), W'(1'b1));
        step();
        rst_ni = 1'b1;
        step();

        // Streaming 1..4 at full rate
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_data = mkd(i);
            step();
            check("stream_in_ready",  W'(in_ready),  W'(1'b1));
            check("stream_out_valid", W'(out_valid), W'(1'b1));
            check("stream_out_data",  out_data, mkd(i));
        end
        in_valid = 1'b0;
        step();
        check("stream_drain_valid", W'(out_valid), W'(1'b0));

        // Backpressure into the skid entry
        out_ready = 1'b0; in_valid = 1'b1; in_data = mkd(10);
        step();
        check("bp_a_data",  out_data, mkd(10));
        check("bp_a_ready", W'(in_ready), W'(1'b1));
        in_data = mkd(11);
        step();
        check("bp_skid_ready", W'(in_ready), W'(1'b0));
        check("bp_hold_a",     out_data, mkd(10));
        in_valid = 1'b0;
        step();
        check("bp_hold_a2",    out_data, mkd(10));
        check("bp_hold_valid", W'(out_valid), W'(1'b1));
        out_ready = 1'b1;
        step();
        check("bp_b_data",  out_data, mkd(11));
        check("bp_b_ready", W'(in_ready), W'(1'b1));
        step();
        check("bp_empty_valid", W'(out_valid), W'(1'b0));

        // Flush from SKID with a coinciding input beat
        out_ready = 1'b0; in_valid = 1'b1; in_data = mkd(20);
        step();
        in_data = mkd(21);
        step();
        check("fl_pre_ready", W'(in_ready), W'(1'b0));
        flush = 1'b1; in_valid = 1'b1; in_data = mkd(22);
        step();
        check("fl_valid", W'(out_valid), W'(1'b0));
        check("fl_data",  out_data, '0);
        check("fl_ready", W'(in_ready), W'(1'b1));
        flush = 1'b0; in_valid = 1'b0;
        step();
        check("fl_c_dropped", W'(out_valid), W'(1'b0));
        flush = 1'b1;
        step();
        check("fl_empty_valid", W'(out_valid), W'(1'b0));
        check("fl_empty_ready", W'(in_ready), W'(1'b1));
        flush = 1'b0;

        // Flush coinciding with an output handshake
        in_valid = 1'b1; in_data = mkd(30);
        step();
        in_valid = 1'b0; out_ready = 1'b1; flush = 1'b1;
        step();
        check("flo_valid", W'(out_valid), W'(1'b0));
        flush = 1'b0;

        // SKID=0 instance: combinational ready, data held on bubble
        s0_in_valid = 1'b1; s0_in_data = 16'h1234; s0_out_ready = 1'b0;
        step();
        check("s0_valid",      W'(s0_out_valid), W'(1'b1));
        check("s0_ready_stall", W'(s0_in_ready), W'(1'b0));
        check("s0_data",       W'(s0_out_data), W'(16'h1234));
        s0_out_ready = 1'b1;
        #1;
        check("s0_ready_comb", W'(s0_in_ready), W'(1'b1));
        s0_in_data = 16'h5678;
        step();
        check("s0_pass_data", W'(s0_out_data), W'(16'h5678));
        s0_in_valid = 1'b0;
        step();
        check("s0_bubble_valid", W'(s0_out_valid), W'(1'b0));
        check("s0_bubble_hold",  W'(s0_out_data), W'(16'h5678));
        s0_out_ready = 1'b0;

        // Asynchronous reset while a beat is held
        out_ready = 1'b0; in_valid = 1'b1; in_data = mkd(40);
        step();
        in_valid = 1'b0;
        check("ar_pre_valid", W'(out_valid), W'(1'b1));
        #2 rst_ni = 1'b0;
        #1;
        check("ar_valid", W'(out_valid), W'(1'b0));
        check("ar_data",  out_data, '0);
        step();
        rst_ni = 1'b1;
        step();
        check("ar_ready", W'(in_ready),  W'(1'b1));
        check("ar_empty", W'(out_valid), W'(1'b0));

`ifdef PIPE_STAGE_PERF_EN
        check("perf_rst_stall", W'(stall_cnt), '0);
        check("perf_rst_flush", W'(flush_cnt), '0);
        in_valid = 1'b1; in_data = mkd(50);
        step();
        in_valid = 1'b0;
        repeat (5) step();
        check("perf_stall5", W'(stall_cnt), W'(32'd5));
        out_ready = 1'b1; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b1; in_data = mkd(51);
        step();
        in_valid = 1'b0; flush = 1'b1;
        step();
        step();
        flush = 1'b0;
        step();
        check("perf_stall", W'(stall_cnt), W'(32'd5));
        check("perf_flush", W'(flush_cnt), W'(32'd2));
`endif

        check("sb_drained", W'(sb.size()), '0);
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
